bin2bcd_seq: RTL

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the 7-segment decoders. Each 4-bit BCD digit of the output bus drives one decoder instance, so register and result values display in decimal instead of hex.
- Start/busy/done handshake.
- The result register holds the last converted value so the displays stay stable between conversions.

---
 rtl/bcd_pkg.sv | 32 +++
 rtl/bcd_add3.sv | 24 ++
 rtl/bin2bcd_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   - FSM state encoding (IDLE, SHIFT)
//   - BCD digit width and the shift-and-add-3 correction constants
//   - helper that returns the minimum digit count for a binary width
// No ports (package).
// -----------------------------------------------------------------------------
package bcd_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT
    } state_t;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] ADD3_INC    = 4'd3;

    // Smallest d with 10^d > 2^width, i.e. floor(width*log10(2)) + 1.
    // 30103/100000 approximates log10(2) closely enough for any practical bus.
    function automatic int bcd_digits(input int width);
        return (width * 30103) / 100000 + 1;
    endfunction

    localparam int DIGITS_16 = bcd_digits(16);   // 5
    localparam int DIGITS_32 = bcd_digits(32);   // 10

endpackage

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Combinational double-dabble correction cell for one BCD digit:
//   corrected = (digit >= 5) ? digit + 3 : digit
// A digit entering this cell is at most 9, so the result never exceeds 12.
// Ports:
//   digit     in  [3:0]  scratch BCD digit before the shift
//   corrected out [3:0]  digit after the add-3 correction
// -----------------------------------------------------------------------------
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] corrected
);

    always_comb begin
        corrected = digit;
        if (digit >= ADD3_THRESH) begin
            corrected = digit + ADD3_INC;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Feeds the 7-segment decoders; bcd holds the last result so the displays
// stay stable between conversions.
//
// Parameters:
//   WIDTH   binary input width (default 16)
//   DIGITS  BCD digits produced (default 5); 10^DIGITS must exceed 2^WIDTH
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   conversion request, sampled only while idle
//   bin    in   [WIDTH-1:0] binary value, captured on the accepting edge
//   bcd    out  [4*DIGITS-1:0] result, digit k in bits [4k+3:4k]
//   busy   out  high while a conversion is in progress
//   done   out  one-cycle pulse on the edge that updates bcd
//   neg    out  sign of the last result (only with BIN2BCD_SIGNED_EN)
//
// Build option:
//   BIN2BCD_SIGNED_EN  treat bin as two's complement; convert the magnitude
//                      and report the sign on neg.
//
// Timing: start sampled at edge T -> bcd/done update at edge T+WIDTH.
// A start present during the done cycle is accepted (state is already IDLE).
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [WIDTH-1:0]              bin,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          busy,
    output logic                          done
`ifdef BIN2BCD_SIGNED_EN
    ,
    output logic                          neg
`endif
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    generate
        if (DIGITS < bcd_digits(WIDTH)) begin : g_digits_check
            $error("bin2bcd_seq: DIGITS too small, 10^DIGITS must exceed 2^WIDTH");
        end
    endgenerate

    state_t             state;
    state_t             state_nxt;
    logic               load;
    logic               step;
    logic               last;

    logic [WIDTH-1:0]   bin_sr;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   scratch_adj;
    logic [BCD_W-1:0]   scratch_shl;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   bin_mag;
    logic               unused_adj_msb;

    // -------------------------------------------------------------------------
    // Input magnitude
    // -------------------------------------------------------------------------
`ifdef BIN2BCD_SIGNED_EN
    logic signed [WIDTH-1:0] bin_s;
    logic                    bin_neg;
    logic                    sign_q;

    // Negation wraps for the most negative value, which yields 2^(WIDTH-1)
    // when read back as unsigned -- exactly the magnitude we want.
    always_comb begin
        bin_s   = signed'(bin);
        bin_neg = bin[WIDTH-1];
        bin_mag = bin_neg ? unsigned'(-bin_s) : bin;
    end
`else
    always_comb begin
        bin_mag = bin;
    end
`endif

    // -------------------------------------------------------------------------
    // Add-3 correction on every scratch digit, then the 1-bit left shift of
    // {scratch, bin_sr}. The top corrected bit is shifted out; the DIGITS
    // constraint guarantees it is always zero.
    // -------------------------------------------------------------------------
    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_add3
            bcd_add3 u_add3 (
                .digit     (scratch[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
                .corrected (scratch_adj[BCD_DIGIT_W*k +: BCD_DIGIT_W])
            );
        end
    endgenerate

    assign scratch_shl    = {scratch_adj[BCD_W-2:0], bin_sr[WIDTH-1]};
    assign unused_adj_msb = scratch_adj[BCD_W-1];

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and datapath controls
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                // This shift brings the counter to zero: publish the result.
                if (cnt == CNT_W'(1)) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state == SHIFT);

    // -------------------------------------------------------------------------
    // Working registers: binary shift register, BCD scratch, bit counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr  <= '0;
            scratch <= '0;
            cnt     <= '0;
        end else if (load) begin
            bin_sr  <= bin_mag;
            scratch <= '0;
            cnt     <= CNT_W'(WIDTH);
        end else if (step) begin
            bin_sr  <= {bin_sr[WIDTH-2:0], 1'b0};
            scratch <= scratch_shl;
            cnt     <= cnt - 1'b1;
        end
    end

`ifdef BIN2BCD_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
        end else if (load) begin
            sign_q <= bin_neg;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Result registers: only updated on the final shift, so bcd never shows a
    // partial value.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd  <= '0;
            done <= 1'b0;
        end else begin
            done <= last;
            if (last) begin
                bcd <= scratch_shl;
            end
        end
    end

`ifdef BIN2BCD_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg <= 1'b0;
        end else if (last) begin
            neg <= sign_q;
        end
    end
`endif

endmodule
